sprite_bank_loader: RTL and testbench

- Writer-side counterpart of the sprite renderer's bitmap ROM. It accepts sprite rows over a valid/ready byte stream into a back bank of a double-buffered 16x8 sprite store.
- It swaps banks only while the renderer is idle (in_progress low), so a frame is never torn.
- The front bank is exposed through the same yofs/bits read interface the renderer's ROM uses. The block drops in place of the fixed car bitmap.

---
 rtl/sprite_bank_loader_pkg.sv | 12 +
 rtl/sprite_bank.sv | 28 ++
 rtl/sprite_bank_loader.sv | 110 +++++++++++
 tb/tb_sprite_bank_loader.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/sprite_bank_loader_pkg.sv
// Shared definitions for the sprite bank loader: default geometry and loader state encodings.
package sprite_bank_loader_pkg;

    localparam int SPR_ROWS  = 16;
    localparam int SPR_WIDTH = 8;

    typedef enum logic {
        LDR_FILL      = 1'b0,
        LDR_FULL_WAIT = 1'b1
    } ldr_state_e;

endpackage

// File: rtl/sprite_bank.sv
// Double-buffered sprite row store: one synchronous write port, one asynchronous read port.
module sprite_bank #(
    parameter int ROWS  = 16,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic             wr_bank,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_bank,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    // Storage is deliberately unreset; bits is masked by front_valid upstream.
    logic [WIDTH-1:0] mem [0:2*ROWS-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[{wr_bank, wr_addr}] <= wr_data;
        end
    end

    assign rd_data = mem[{rd_bank, rd_addr}];

endmodule

// File: rtl/sprite_bank_loader.sv
// Streams sprite rows into the back bank and swaps banks only while the renderer is idle.
module sprite_bank_loader
    import sprite_bank_loader_pkg::*;
#(
    parameter int ROWS  = SPR_ROWS,
    parameter int WIDTH = SPR_WIDTH,
    localparam int AW   = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_last,
    input  logic             in_progress,
    input  logic [AW-1:0]    yofs,
    output logic [WIDTH-1:0] bits,
    output logic             swap_done,
    output logic             error
);

    localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);

    ldr_state_e       state;
    ldr_state_e       state_nxt;
    logic [AW-1:0]    wptr;
    logic             front_sel;
    logic             front_valid;
    logic             accept;
    logic             swap;
    logic             at_last_row;
    logic [WIDTH-1:0] front_data;

    assign accept      = wr_valid && wr_ready;
    assign at_last_row = (wptr == LAST_ROW);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= LDR_FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LDR_FILL: begin
                if (accept && at_last_row && wr_last) begin
                    state_nxt = LDR_FULL_WAIT;
                end
            end
            LDR_FULL_WAIT: begin
                if (!in_progress) begin
                    state_nxt = LDR_FILL;
                end
            end
            default: state_nxt = LDR_FILL;
        endcase
    end

    always_comb begin
        wr_ready = (state == LDR_FILL);
        swap     = (state == LDR_FULL_WAIT) && !in_progress;
    end

    // Any frame boundary, good or bad, rewinds the pointer; a mismatch only flags it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr        <= '0;
            front_sel   <= 1'b0;
            front_valid <= 1'b0;
            swap_done   <= 1'b0;
            error       <= 1'b0;
        end else begin
            swap_done <= swap;
            if (accept) begin
                if (at_last_row || wr_last) begin
                    wptr <= '0;
                end else begin
                    wptr <= wptr + AW'(1);
                end
                if (at_last_row != wr_last) begin
                    error <= 1'b1;
                end
            end
            if (swap) begin
                front_sel   <= ~front_sel;
                front_valid <= 1'b1;
            end
        end
    end

    sprite_bank #(
        .ROWS  (ROWS),
        .WIDTH (WIDTH)
    ) u_bank (
        .clk     (clk),
        .we      (accept),
        .wr_bank (~front_sel),
        .wr_addr (wptr),
        .wr_data (wr_data),
        .rd_bank (front_sel),
        .rd_addr (yofs),
        .rd_data (front_data)
    );

    assign bits = front_valid ? front_data : '0;

endmodule

// File: tb/tb_sprite_bank_loader.sv
// Directed bench for sprite_bank_loader: framing, deferred swap, backpressure and reset.
module tb_sprite_bank_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [7:0] wr_data = 8'h00;
    logic       wr_last = 1'b0;
    logic       in_progress = 1'b0;
    logic [3:0] yofs = 4'd0;
    logic [7:0] bits;
    logic       swap_done;
    logic       error;

    int errs = 0;
    int checks = 0;
    int swap_cnt = 0;

    sprite_bank_loader dut (
        .clk         (clk),
        .reset       (reset),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_data     (wr_data),
        .wr_last     (wr_last),
        .in_progress (in_progress),
        .yofs        (yofs),
        .bits        (bits),
        .swap_done   (swap_done),
        .error       (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (swap_done) swap_cnt <= swap_cnt + 1;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        int n;
        n = 0;
        wr_valid = 1'b1;
        wr_data  = d;
        wr_last  = last;
        while (!wr_ready && n < 2000) begin
            step(1);
            n++;
        end
        if (!wr_ready) chk("send_timeout", 32'd0, 32'd1);
        step(1);
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        wr_data  = 8'hEE;
    endtask

    task automatic idle_gap(input int n);
        wr_valid = 1'b0;
        wr_data  = 8'hEE;
        wr_last  = 1'b1;
        step(n);
        wr_last  = 1'b0;
    endtask

    initial begin
        int base;
        int bad;

        // Reset then idle
        step(2);
        reset = 1'b1;
        step(1);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_swap_done", swap_done, 0);
        chk("rst_error", error, 0);
        bad = 0;
        for (int k = 0; k < 16; k++) begin
            yofs = 4'(k);
            #1;
            if (bits !== 8'h00) bad++;
        end
        chk("rst_bits_zero", bad, 0);

        // Frame load with renderer idle
        base = swap_cnt;
        for (int k = 0; k < 16; k++) send(8'(k + 1), k == 15);
        chk("load_ready_low", wr_ready, 0);
        chk("load_bits_before_swap", bits, 8'h00);
        chk("load_no_early_swap", swap_done, 0);
        step(1);
        chk("load_swap_done", swap_done, 1);
        bad = 0;
        for (int k = 0; k < 16; k++) begin
            yofs = 4'(k);
            #1;
            if (bits !== 8'(k + 1)) bad++;
        end
        chk("load_rows", bad, 0);
        step(1);
        chk("load_swap_done_clear", swap_done, 0);
        chk("load_swap_once", swap_cnt - base, 1);
        chk("load_ready_back", wr_ready, 1);

        // Swap deferred while renderer busy
        in_progress = 1'b1;
        yofs = 4'd3;
        base = swap_cnt;
        for (int k = 0; k < 16; k++) send(8'hFF, k == 15);
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            if (wr_ready !== 1'b0 || bits !== 8'h04 || swap_done !== 1'b0) bad++;
            step(1);
        end
        chk("defer_hold", bad, 0);
        in_progress = 1'b0;
        step(1);
        chk("defer_swap_done", swap_done, 1);
        chk("defer_bits", bits, 8'hFF);
        step(1);
        chk("defer_swap_done_clear", swap_done, 0);
        chk("defer_bits_hold", bits, 8'hFF);
        chk("defer_swap_once", swap_cnt - base, 1);

        // Early wr_last on the 5th byte
        base = swap_cnt;
        for (int k = 0; k < 5; k++) send(8'hA0 + 8'(k), k == 4);
        chk("early_error", error, 1);
        chk("early_ready", wr_ready, 1);
        step(3);
        chk("early_no_swap", swap_cnt - base, 0);
        chk("early_bits_hold", bits, 8'hFF);
        for (int k = 0; k < 16; k++) send(8'h20 + 8'(k), k == 15);
        step(2);
        chk("early_recover_swaps", swap_cnt - base, 1);
        yofs = 4'd0;
        #1;
        chk("early_recover_row0", bits, 8'h20);
        yofs = 4'd15;
        #1;
        chk("early_recover_row15", bits, 8'h2F);
        chk("early_error_sticky", error, 1);

        // Backpressure, then reset after 8 bytes
        for (int k = 0; k < 8; k++) begin
            idle_gap($urandom_range(0, 2));
            send(8'h80 + 8'(k), 1'b0);
        end
        reset = 1'b0;
        #1;
        chk("mid_rst_bits", bits, 8'h00);
        chk("mid_rst_error", error, 0);
        step(1);
        reset = 1'b1;
        step(1);
        base = swap_cnt;
        chk("mid_rst_ready", wr_ready, 1);

        // Missing wr_last after reset
        for (int k = 0; k < 16; k++) send(8'h55, 1'b0);
        step(3);
        chk("miss_error", error, 1);
        chk("miss_no_swap", swap_cnt - base, 0);
        chk("miss_ready", wr_ready, 1);
        chk("miss_bits_zero", bits, 8'h00);

        // Good frame with random gaps lands in the right rows
        for (int k = 0; k < 16; k++) begin
            idle_gap($urandom_range(0, 3));
            send(8'h60 + 8'(k), k == 15);
        end
        step(1);
        chk("gap_swap_done", swap_done, 1);
        bad = 0;
        for (int k = 0; k < 16; k++) begin
            yofs = 4'(k);
            #1;
            if (bits !== 8'h60 + 8'(k)) bad++;
        end
        chk("gap_rows", bad, 0);
        step(2);
        chk("gap_swap_once", swap_cnt - base, 1);
        chk("gap_error_sticky", error, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
